// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue between imem and dec.
// Circular FIFO of {ins, pc} entries. Accepts 0-2 instructions per cycle and
// presents the two oldest entries, in program order, as the i1/i2 pair.
// A redirect (flush) discards every entry.
module fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rs_n,
  input  logic          flush,
  input  logic [1:0]    in_valid,
  input  logic [31:0]   in_ins1,
  input  logic [31:0]   in_ins2,
  input  logic [31:0]   in_pc,
  output logic          in_ready,
  output logic [1:0]    out_valid,
  output logic [31:0]   out_ins1,
  output logic [31:0]   out_ins2,
  output logic [31:0]   out_pc1,
  output logic [31:0]   out_pc2,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  localparam int unsigned CW = AW + 1;
  // Highest occupancy at which a full pair still fits.
  localparam logic [AW:0] ReadyMax = CW'(DEPTH - 2);

  logic [31:0]   mem_ins [DEPTH];
  logic [31:0]   mem_pc  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_nxt1;
  logic [AW-1:0] rd_ptr_nxt1;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;

  // Pair slots wrap naturally modulo DEPTH through the AW-bit pointers.
  assign wr_ptr_nxt1 = wr_ptr + AW'(1);
  assign rd_ptr_nxt1 = rd_ptr + AW'(1);

  // Status flags are derived from the registered count only.
  always_comb begin
    in_ready     = (count <= ReadyMax);
    out_valid[0] = (count != '0);
    out_valid[1] = (count >= CW'(2));
  end

  // Number of entries written and consumed this cycle; flush cancels both.
  always_comb begin
    push_n = 2'd0;
    pop_n  = 2'd0;
    if (in_ready && !flush) begin
      case (in_valid)
        2'b01:   push_n = 2'd1;
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;  // 2'b10 is illegal and ignored
      endcase
    end
    if (out_ready && !flush) begin
      case (out_valid)
        2'b01:   pop_n = 2'd1;
        2'b11:   pop_n = 2'd2;
        default: pop_n = 2'd0;
      endcase
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      mem_ins[wr_ptr] <= in_ins1;
      mem_pc[wr_ptr]  <= in_pc;
    end
    if (push_n == 2'd2) begin
      mem_ins[wr_ptr_nxt1] <= in_ins2;
      mem_pc[wr_ptr_nxt1]  <= in_pc + 32'd4;
    end
  end

  // Pointer and occupancy state; flush outranks any push or pop.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Invalid output slots drive zero so dec sees a nop.
  always_comb begin
    out_ins1 = out_valid[0] ? mem_ins[rd_ptr]      : 32'b0;
    out_pc1  = out_valid[0] ? mem_pc[rd_ptr]       : 32'b0;
    out_ins2 = out_valid[1] ? mem_ins[rd_ptr_nxt1] : 32'b0;
    out_pc2  = out_valid[1] ? mem_pc[rd_ptr_nxt1]  : 32'b0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model by a negedge monitor.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rs_n = 1'b1;
  logic          flush = 1'b0;
  logic [1:0]    in_valid = 2'b00;
  logic [31:0]   in_ins1 = '0;
  logic [31:0]   in_ins2 = '0;
  logic [31:0]   in_pc = '0;
  logic          in_ready;
  logic [1:0]    out_valid;
  logic [31:0]   out_ins1;
  logic [31:0]   out_ins2;
  logic [31:0]   out_pc1;
  logic [31:0]   out_pc2;
  logic          out_ready = 1'b0;
  logic [AW:0]   count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Expected contents, oldest first: {ins, pc}.
  logic [63:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rs_n      (rs_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ins1   (in_ins1),
    .in_ins2   (in_ins2),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ins1  (out_ins1),
    .out_ins2  (out_ins2),
    .out_pc1   (out_pc1),
    .out_pc2   (out_pc2),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO semantics with flush priority and 2-entry headroom rule.
  always @(posedge clk or negedge rs_n) begin
    int pre;
    int npop;
    if (!rs_n) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      pre = exp_q.size();
      npop = 0;
      if (out_ready) npop = (pre >= 2) ? 2 : pre;
      for (int k = 0; k < npop; k++) void'(exp_q.pop_front());
      if (pre <= int'(DEPTH) - 2) begin
        if (in_valid == 2'b01) begin
          exp_q.push_back({in_ins1, in_pc});
        end else if (in_valid == 2'b11) begin
          exp_q.push_back({in_ins1, in_pc});
          exp_q.push_back({in_ins2, in_pc + 32'd4});
        end
      end
    end
  end

  // Monitor: compare everything the DUT presents against the model head.
  always @(negedge clk) begin
    int sz;
    if (rs_n) begin
      sz = exp_q.size();
      chk("count", 64'(count), 64'(sz));
      chk("in_ready", 64'(in_ready), 64'(sz <= int'(DEPTH) - 2));
      chk("out_valid", 64'(out_valid), 64'({sz >= 2, sz >= 1}));
      if (sz >= 1) begin
        chk("out_ins1", 64'(out_ins1), 64'(exp_q[0][63:32]));
        chk("out_pc1", 64'(out_pc1), 64'(exp_q[0][31:0]));
      end else begin
        chk("out_ins1_nop", 64'({out_ins1, out_pc1}), 64'd0);
      end
      if (sz >= 2) begin
        chk("out_ins2", 64'(out_ins2), 64'(exp_q[1][63:32]));
        chk("out_pc2", 64'(out_pc2), 64'(exp_q[1][31:0]));
      end else begin
        chk("out_ins2_nop", 64'({out_ins2, out_pc2}), 64'd0);
      end
    end
  end

  // Hold inputs for one cycle, return just after the edge.
  task automatic drive(input logic f, input logic [1:0] iv, input logic ordy,
                       input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] pc);
    flush     = f;
    in_valid  = iv;
    out_ready = ordy;
    in_ins1   = i1;
    in_ins2   = i2;
    in_pc     = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd(input logic f, input logic [1:0] iv, input logic ordy);
    drive(f, iv, ordy, $urandom, $urandom, $urandom & 32'hffff_fffc);
  endtask

  initial begin
    int steady;
    logic [1:0] iv;

    // Reset state.
    #1 rs_n = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 rs_n = 1'b1;

    // 1: single pair push, visible next cycle.
    drive(1'b0, 2'b11, 1'b0, 32'haaaa_0001, 32'hbbbb_0002, 32'h0000_0100);
    chk("t1_out_valid", 64'(out_valid), 64'h3);
    chk("t1_out_ins1", 64'(out_ins1), 64'haaaa_0001);
    chk("t1_out_pc2", 64'(out_pc2), 64'h104);
    chk("t1_count", 64'(count), 64'd2);

    // 2: fill to DEPTH-1, next push dropped.
    rnd(1'b0, 2'b11, 1'b0);
    rnd(1'b0, 2'b11, 1'b0);
    rnd(1'b0, 2'b01, 1'b0);
    chk("t2_count7", 64'(count), 64'(DEPTH - 1));
    chk("t2_in_ready", 64'(in_ready), 64'd0);
    rnd(1'b0, 2'b11, 1'b0);
    chk("t2_dropped", 64'(count), 64'(DEPTH - 1));

    // 3: drain 2/cycle while pushing 2/cycle, across the wrap.
    rnd(1'b0, 2'b11, 1'b1);  // push dropped at 7, pops 2 -> 5
    steady = int'(count);
    for (int i = 0; i < 10; i++) rnd(1'b0, 2'b11, 1'b1);
    chk("t3_count_const", 64'(count), 64'(steady));

    // 4: flush with simultaneous push and pop at count=5.
    chk("t4_count5", 64'(count), 64'd5);
    rnd(1'b1, 2'b11, 1'b1);
    chk("t4_count0", 64'(count), 64'd0);
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_out_ins1", 64'(out_ins1), 64'd0);

    // 5: single entry popped.
    rnd(1'b0, 2'b01, 1'b0);
    chk("t5_valid_before", 64'(out_valid), 64'h1);
    chk("t5_ins2_before", 64'(out_ins2), 64'd0);
    rnd(1'b0, 2'b00, 1'b1);
    chk("t5_valid_after", 64'(out_valid), 64'h0);
    chk("t5_ins2_after", 64'(out_ins2), 64'd0);

    // 6: illegal in_valid=10 ignored, then async reset mid-burst.
    rnd(1'b0, 2'b10, 1'b0);
    chk("t6_illegal", 64'(count), 64'd0);
    rnd(1'b0, 2'b11, 1'b0);
    rnd(1'b0, 2'b11, 1'b0);
    #2 rs_n = 1'b0;
    #1;
    chk("t6_async_count", 64'(count), 64'd0);
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    #3 rs_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0:       iv = 2'b10;
        1, 2, 3: iv = 2'b01;
        4, 5, 6: iv = 2'b11;
        default: iv = 2'b00;
      endcase
      rnd(($urandom_range(0, 39) == 0), iv, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
